// File: rtl/life_pkg.sv
// life_pkg: shared constants and helpers for the Game of Life world buffer.
//   - default cell colors (RRR_GGG_BB)
//   - CTRL register bit positions
//   - clear/copy engine state encoding
//   - derived world geometry (word count, words per row)
package life_pkg;

  localparam logic [7:0] DEF_COLOR_ALIVE   = 8'b000_000_00;
  localparam logic [7:0] DEF_COLOR_EMPTY   = 8'b111_111_11;
  localparam logic [7:0] DEF_COLOR_POINTER = 8'b110_110_10;
  localparam logic [7:0] DEF_COLOR_GRID    = 8'b100_100_10;
  localparam logic [7:0] DEF_COLOR_OUTSIDE = 8'b000_000_00;

  localparam int CTRL_SWAP    = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_COPY    = 2;
  localparam int CTRL_GRID_LD = 4;
  localparam int CTRL_GRID_EN = 5;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_CLEAR = 2'd1,
    ENG_COPY  = 2'd2
  } eng_state_t;

  function automatic int world_words(int width, int height);
    return (width * height) / 32;
  endfunction

  function automatic int row_words(int width);
    return width / 32;
  endfunction

endpackage

// File: rtl/life_pixel_pipe.sv
// life_pixel_pipe: 2-stage VGA pixel pipeline.
//   Stage 1 maps pixel x/y to cell coordinates and registers edge/visible/
//   in-world flags. Stage 2 reads the front-buffer word through rd_addr/rd_data
//   (combinational memory port) and registers the final color.
// Ports:
//   clock, reset_n            clock, async active-low reset
//   x_position, y_position    current pixel
//   inside_video              pixel is in the visible area
//   grid_en, cursor_*         overlay controls
//   rd_addr / rd_data         front-buffer word read port
//   color                     registered pixel color (2 clocks after x/y)
module life_pixel_pipe
  import life_pkg::*;
#(
  parameter int          WORLD_WIDTH   = 64,
  parameter int          WORLD_HEIGHT  = 48,
  parameter int          CELL_PIXELS   = 10,
  parameter int          ADDR_WIDTH    = 7,
  parameter logic [7:0]  COLOR_ALIVE   = DEF_COLOR_ALIVE,
  parameter logic [7:0]  COLOR_EMPTY   = DEF_COLOR_EMPTY,
  parameter logic [7:0]  COLOR_POINTER = DEF_COLOR_POINTER,
  parameter logic [7:0]  COLOR_GRID    = DEF_COLOR_GRID,
  parameter logic [7:0]  COLOR_OUTSIDE = DEF_COLOR_OUTSIDE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [9:0]            x_position,
  input  logic [8:0]            y_position,
  input  logic                  inside_video,
  input  logic                  grid_en,
  input  logic                  cursor_en,
  input  logic [7:0]            cursor_x,
  input  logic [7:0]            cursor_y,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic [7:0]            color
);

  localparam int ROW_WORDS = row_words(WORLD_WIDTH);

  logic [9:0] cx;
  logic [8:0] cy;
  assign cx = x_position / 10'(CELL_PIXELS);
  assign cy = y_position / 9'(CELL_PIXELS);

  logic [9:0] s1_cx;
  logic [8:0] s1_cy;
  logic       s1_edge, s1_vid, s1_inw;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_cx   <= '0;
      s1_cy   <= '0;
      s1_edge <= 1'b0;
      s1_vid  <= 1'b0;
      s1_inw  <= 1'b0;
    end else begin
      s1_cx   <= cx;
      s1_cy   <= cy;
      s1_edge <= (x_position % 10'(CELL_PIXELS) == 10'd0) ||
                 (y_position % 9'(CELL_PIXELS) == 9'd0);
      s1_vid  <= inside_video;
      s1_inw  <= (cx < 10'(WORLD_WIDTH)) && (cy < 9'(WORLD_HEIGHT));
    end
  end

  // Out-of-world coordinates produce a meaningless address; s1_inw masks it.
  assign rd_addr = ADDR_WIDTH'(s1_cy) * ADDR_WIDTH'(ROW_WORDS) + ADDR_WIDTH'(s1_cx >> 5);

  logic alive, cursor_hit;
  assign alive      = rd_data[s1_cx[4:0]];
  assign cursor_hit = (s1_cx == {2'b00, cursor_x}) && (s1_cy == {1'b0, cursor_y});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     color <= '0;
    else if (!s1_vid)                 color <= '0;
    else if (!s1_inw)                 color <= COLOR_OUTSIDE;
    else if (grid_en && s1_edge)      color <= COLOR_GRID;
    else if (cursor_en && cursor_hit) color <= COLOR_POINTER;
    else if (alive)                   color <= COLOR_ALIVE;
    else                              color <= COLOR_EMPTY;
  end

endmodule

// File: rtl/life_world_buffer.sv
// life_world_buffer: double-buffered Game of Life cell world.
//   CPU reads the front buffer and writes the back buffer one 32-cell word at
//   a time. Two top addresses hold CTRL/STATUS and CURSOR. Buffer swaps wait
//   for a vblank rising edge; a clear/copy engine fills the back buffer one
//   word per cycle. The VGA side reads the front buffer via life_pixel_pipe.
// Ports:
//   clock, reset_n                clock, async active-low reset
//   cell_write/address/data_in    CPU write port (one word per cycle)
//   cell_data_out                 CPU read data (combinational)
//   x_position, y_position,
//   inside_video, vblank          VGA timing inputs
//   busy                          clear/copy engine active
//   color                         registered pixel color
module life_world_buffer
  import life_pkg::*;
#(
  parameter int          WORLD_WIDTH   = 64,
  parameter int          WORLD_HEIGHT  = 48,
  parameter int          CELL_PIXELS   = 10,
  parameter int          ADDR_WIDTH    = 7,
  parameter logic [7:0]  COLOR_ALIVE   = DEF_COLOR_ALIVE,
  parameter logic [7:0]  COLOR_EMPTY   = DEF_COLOR_EMPTY,
  parameter logic [7:0]  COLOR_POINTER = DEF_COLOR_POINTER,
  parameter logic [7:0]  COLOR_GRID    = DEF_COLOR_GRID,
  parameter logic [7:0]  COLOR_OUTSIDE = DEF_COLOR_OUTSIDE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cell_write,
  input  logic [ADDR_WIDTH-1:0] cell_address,
  input  logic [31:0]           cell_data_in,
  output logic [31:0]           cell_data_out,
  input  logic [9:0]            x_position,
  input  logic [8:0]            y_position,
  input  logic                  inside_video,
  input  logic                  vblank,
  output logic                  busy,
  output logic [7:0]            color
);

  localparam int WORDS     = world_words(WORLD_WIDTH, WORLD_HEIGHT);
  localparam int ROW_WORDS = row_words(WORLD_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = '1;
  localparam logic [ADDR_WIDTH-1:0] CURSOR_ADDR = CTRL_ADDR - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] WORDS_A     = ADDR_WIDTH'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(WORDS - 1);

  typedef logic [WORDS-1:0][31:0] world_t;

  // Power-on image of buffer 0: a glider at (1,0),(2,1),(0,2),(1,2),(2,2).
  function automatic world_t glider_init();
    world_t m;
    m = '0;
    m[0][1]                 = 1'b1;
    m[ROW_WORDS][2]         = 1'b1;
    m[2 * ROW_WORDS][2:0]   = 3'b111;
    return m;
  endfunction

  // Storage is deliberately never reset.
  world_t buf0 = glider_init();
  world_t buf1;

  eng_state_t            state;
  logic [ADDR_WIDTH-1:0] eng_idx;
  logic                  front, swap_pending, grid_en, cursor_en, vblank_q;
  logic [7:0]            cursor_x, cursor_y;

  assign busy = (state != ENG_IDLE);

  logic world_hit, ctrl_wr, cursor_wr, swap_req, do_swap;
  assign world_hit = cell_address < WORDS_A;
  assign ctrl_wr   = cell_write && (cell_address == CTRL_ADDR);
  assign cursor_wr = cell_write && (cell_address == CURSOR_ADDR);
  // A CTRL swap request in the same cycle as a vblank edge counts at that edge.
  assign swap_req  = swap_pending || (ctrl_wr && cell_data_in[CTRL_SWAP]);
  assign do_swap   = vblank && !vblank_q && swap_req && !busy;

  // Front-buffer read ports: CPU, engine copy source, pixel pipe.
  logic [31:0]           cpu_front, eng_src, pix_word;
  logic [ADDR_WIDTH-1:0] pix_addr;
  assign cpu_front = front ? buf1[cell_address] : buf0[cell_address];
  assign eng_src   = front ? buf1[eng_idx]      : buf0[eng_idx];
  assign pix_word  = (pix_addr < WORDS_A) ? (front ? buf1[pix_addr] : buf0[pix_addr]) : '0;

  // Back-buffer write port: the engine owns it while busy, CPU writes drop.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [31:0]           mem_wd;
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cell_address;
    mem_wd = cell_data_in;
    if (busy) begin
      mem_we = 1'b1;
      mem_wa = eng_idx;
      mem_wd = (state == ENG_COPY) ? eng_src : '0;
    end else if (cell_write && world_hit) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      if (front) buf0[mem_wa] <= mem_wd;
      else       buf1[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ENG_IDLE;
      eng_idx      <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      vblank_q     <= 1'b0;
      grid_en      <= 1'b0;
      cursor_en    <= 1'b0;
      cursor_x     <= '0;
      cursor_y     <= '0;
    end else begin
      vblank_q <= vblank;
      if (do_swap) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (ctrl_wr && cell_data_in[CTRL_GRID_LD]) grid_en <= cell_data_in[CTRL_GRID_EN];
      if (cursor_wr) begin
        cursor_en <= cell_data_in[31];
        cursor_y  <= cell_data_in[15:8];
        cursor_x  <= cell_data_in[7:0];
      end
      case (state)
        ENG_IDLE: begin
          // Clear wins when both starts are requested; the copy is discarded.
          if (ctrl_wr && cell_data_in[CTRL_CLEAR]) begin
            state   <= ENG_CLEAR;
            eng_idx <= '0;
          end else if (ctrl_wr && cell_data_in[CTRL_COPY]) begin
            state   <= ENG_COPY;
            eng_idx <= '0;
          end
        end
        default: begin
          if (eng_idx == LAST_WORD) state <= ENG_IDLE;
          else                      eng_idx <= eng_idx + ADDR_WIDTH'(1);
        end
      endcase
    end
  end

  always_comb begin
    cell_data_out = '0;
    if (cell_address == CTRL_ADDR)
      cell_data_out = {28'b0, grid_en, busy, swap_pending, front};
    else if (cell_address == CURSOR_ADDR)
      cell_data_out = {cursor_en, 15'b0, cursor_y, cursor_x};
    else if (world_hit)
      cell_data_out = cpu_front;
  end

  life_pixel_pipe #(
    .WORLD_WIDTH  (WORLD_WIDTH),
    .WORLD_HEIGHT (WORLD_HEIGHT),
    .CELL_PIXELS  (CELL_PIXELS),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .COLOR_ALIVE  (COLOR_ALIVE),
    .COLOR_EMPTY  (COLOR_EMPTY),
    .COLOR_POINTER(COLOR_POINTER),
    .COLOR_GRID   (COLOR_GRID),
    .COLOR_OUTSIDE(COLOR_OUTSIDE)
  ) u_pix (
    .clock       (clock),
    .reset_n     (reset_n),
    .x_position  (x_position),
    .y_position  (y_position),
    .inside_video(inside_video),
    .grid_en     (grid_en),
    .cursor_en   (cursor_en),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .rd_addr     (pix_addr),
    .rd_data     (pix_word),
    .color       (color)
  );

endmodule
